crcu_apb_seq: RTL and testbench

Parametrised clock/reset control unit with an APB3 slave register file. It drives one clock-enable and one active-low reset per downstream channel: SPU, VPU, CPM, LD, wide IOL, TAP, debug, VP debug, and more as NUM_CH grows. A hardware sequencer walks the channels in index order. For each channel still in reset it enables the clock, holds for a programmable time, then releases reset. Sits beside the master clock/reset distribution; clock-enables feed external ICG cells.

---
 rtl/crcu_apb_seq_if.sv | 23 ++
 rtl/crcu_apb_seq.sv | 183 ++++++++++++++++++
 tb/tb_crcu_apb_seq.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crcu_apb_seq_if.sv
// APB3 slave bus bundle for the clock/reset control unit.
interface crcu_apb_seq_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/crcu_apb_seq.sv
// Clock/reset control unit: APB3 register file plus a sequencer that brings channels out of reset.
// Optional soft-reset register at 0x14 is enabled by defining CRCU_SOFT_RST_EN.
module crcu_apb_seq #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned HOLD_W = 8
) (
  input  logic               i_pclk,
  input  logic               i_presetn,
  crcu_apb_seq_if.slave      io_apb,
  output logic [NUM_CH-1:0]  o_ch_clk_en,
  output logic [NUM_CH-1:0]  o_ch_rst_n,
  output logic               o_seq_busy,
  output logic               o_seq_done_irq
);

  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [ADDR_W-1:0] AddrClkEn  = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] AddrRst    = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] AddrCfg    = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] AddrCtrl   = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] AddrId     = ADDR_W'(32'h10);
  localparam logic [31:0]       IdValue    = {16'hC2C0, 8'(NUM_CH), 8'h02};

  typedef enum logic [2:0] {
    StIdle, StScan, StClkOn, StHoldClk, StRel, StHoldRel, StNext
  } state_e;

  state_e            r_state, w_state_d;
  logic [IdxW-1:0]   r_idx, w_idx_d;
  logic [HOLD_W-1:0] r_cnt, w_cnt_d;
  logic [HOLD_W-1:0] r_gap;
  logic [NUM_CH-1:0] r_clk_en, r_rst_assert;
  logic              r_done, r_irq;

  logic w_busy, w_access, w_aligned, w_mapped, w_err, w_wr;
  logic w_sel_clk, w_sel_rst, w_sel_cfg, w_sel_ctrl, w_sel_id, w_sel_swrst;
  logic w_start, w_clr_done, w_soft_rst, w_bad_key;
  logic w_set_clk, w_clr_rst, w_fin;
  logic [31:0] w_prdata;

  assign w_busy    = (r_state != StIdle);
  assign w_access  = io_apb.PSEL & io_apb.PENABLE;
  assign w_aligned = (io_apb.PADDR[1:0] == 2'b00);

  assign w_sel_clk  = (io_apb.PADDR == AddrClkEn);
  assign w_sel_rst  = (io_apb.PADDR == AddrRst);
  assign w_sel_cfg  = (io_apb.PADDR == AddrCfg);
  assign w_sel_ctrl = (io_apb.PADDR == AddrCtrl);
  assign w_sel_id   = (io_apb.PADDR == AddrId);

`ifdef CRCU_SOFT_RST_EN
  assign w_sel_swrst = (io_apb.PADDR == ADDR_W'(32'h14));
  assign w_bad_key   = (io_apb.PWDATA != 32'h0000_5AFE);
`else
  assign w_sel_swrst = 1'b0;
  assign w_bad_key   = 1'b0;
`endif

  assign w_mapped = w_sel_clk | w_sel_rst | w_sel_cfg | w_sel_ctrl | w_sel_id | w_sel_swrst;

  // Any erroring access is dropped entirely, so w_wr already excludes it.
  assign w_err = w_access & (!w_aligned | !w_mapped
               | (io_apb.PWRITE & w_sel_id)
               | (io_apb.PWRITE & w_busy & (w_sel_clk | w_sel_rst))
               | (io_apb.PWRITE & w_sel_swrst & w_bad_key));
  assign w_wr  = w_access & io_apb.PWRITE & !w_err;

  assign w_start    = w_wr & w_sel_ctrl & io_apb.PWDATA[0] & !w_busy;
  assign w_clr_done = w_wr & w_sel_ctrl & io_apb.PWDATA[1];
  assign w_soft_rst = w_wr & w_sel_swrst;

  always_comb begin
    w_prdata = '0;
    if (w_access & !io_apb.PWRITE) begin
      if (w_sel_clk)       w_prdata = 32'(r_clk_en);
      else if (w_sel_rst)  w_prdata = 32'(r_rst_assert);
      else if (w_sel_cfg)  w_prdata = 32'(r_gap);
      else if (w_sel_ctrl) w_prdata = {30'b0, r_done, w_busy};
      else if (w_sel_id)   w_prdata = IdValue;
    end
  end

  assign io_apb.PRDATA  = w_prdata;
  assign io_apb.PREADY  = 1'b1;
  assign io_apb.PSLVERR = w_err;

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_cnt_d   = r_cnt;
    w_set_clk = 1'b0;
    w_clr_rst = 1'b0;
    w_fin     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_d = StScan;
          w_idx_d   = '0;
        end
      end
      StScan:    w_state_d = r_rst_assert[r_idx] ? StClkOn : StNext;
      StClkOn: begin
        w_set_clk = 1'b1;
        w_cnt_d   = r_gap;
        w_state_d = StHoldClk;
      end
      StHoldClk: begin
        if (r_cnt == '0) w_state_d = StRel;
        else             w_cnt_d   = r_cnt - HOLD_W'(1);
      end
      StRel: begin
        w_clr_rst = 1'b1;
        w_cnt_d   = r_gap;
        w_state_d = StHoldRel;
      end
      StHoldRel: begin
        if (r_cnt == '0) w_state_d = StNext;
        else             w_cnt_d   = r_cnt - HOLD_W'(1);
      end
      StNext: begin
        if (r_idx == IdxW'(NUM_CH - 1)) begin
          w_fin     = 1'b1;
          w_state_d = StIdle;
        end else begin
          w_idx_d   = r_idx + IdxW'(1);
          w_state_d = StScan;
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Soft reset aborts whatever the sequencer was about to do, including the irq.
    if (w_soft_rst) begin
      w_state_d = StIdle;
      w_set_clk = 1'b0;
      w_clr_rst = 1'b0;
      w_fin     = 1'b0;
    end
  end

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_clk_en     <= '0;
      r_rst_assert <= '1;
      r_gap        <= '0;
      r_done       <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_irq <= w_fin;
      if (w_wr & w_sel_clk) r_clk_en     <= io_apb.PWDATA[NUM_CH-1:0];
      if (w_wr & w_sel_rst) r_rst_assert <= io_apb.PWDATA[NUM_CH-1:0];
      if (w_wr & w_sel_cfg) r_gap        <= io_apb.PWDATA[HOLD_W-1:0];
      if (w_set_clk) r_clk_en[r_idx]     <= 1'b1;
      if (w_clr_rst) r_rst_assert[r_idx] <= 1'b0;
      if (w_clr_done | w_start) r_done <= 1'b0;
      if (w_fin)                r_done <= 1'b1;
      if (w_soft_rst) begin
        r_clk_en     <= '0;
        r_rst_assert <= '1;
        r_done       <= 1'b0;
      end
    end
  end

  assign o_ch_clk_en    = r_clk_en;
  assign o_ch_rst_n     = ~r_rst_assert;
  assign o_seq_busy     = w_busy;
  assign o_seq_done_irq = r_irq;

endmodule

// File: tb/tb_crcu_apb_seq.sv
// Self-checking bench for crcu_apb_seq: register table, timed sequencer model, reset/abort corners.
module tb_crcu_apb_seq;
  localparam int unsigned NUM_CH = 8;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned HOLD_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  crcu_apb_seq_if #(.ADDR_W(ADDR_W)) apb ();

  logic [NUM_CH-1:0] ch_clk_en, ch_rst_n;
  logic              seq_busy, seq_done_irq;

  crcu_apb_seq #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .HOLD_W(HOLD_W)) dut (
    .i_pclk        (clk),
    .i_presetn     (rst_n),
    .io_apb        (apb),
    .o_ch_clk_en   (ch_clk_en),
    .o_ch_rst_n    (ch_rst_n),
    .o_seq_busy    (seq_busy),
    .o_seq_done_irq(seq_done_irq)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int mon_irq = 0;
  int mon_busy = 0;

  always @(negedge clk) begin
    if (seq_done_irq) mon_irq <= mon_irq + 1;
    if (seq_busy)     mon_busy <= mon_busy + 1;
  end

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       exp_rdata;
    logic              exp_err;
    string             name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input string name);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                           output logic err);
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = addr; apb.PWDATA = data;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    #1 err = apb.PSLVERR;
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [ADDR_W-1:0] addr, output logic [31:0] data,
                          output logic err);
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = addr;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    #1 data = apb.PRDATA; err = apb.PSLVERR;
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  // Reference timing: each sequenced channel costs 2*gap+6 cycles, each skipped one 2;
  // clock enable lands 2 cycles into a channel slot, reset release gap+2 cycles later.
  task automatic run_seq(input string tag, input int gap, input logic [NUM_CH-1:0] clk0,
                         input logic [NUM_CH-1:0] rst0);
    logic err;
    logic [31:0] rd;
    int set_t[NUM_CH];
    int rel_t[NUM_CH];
    int t;
    logic [NUM_CH-1:0] e_clk, e_rn;
    logic [31:0] a_c, x_c, a_r, x_r, a_b, x_b, a_i, x_i;
    logic bad_c, bad_r, bad_b, bad_i;
    apb_write(12'h008, 32'(gap), err);
    apb_write(12'h000, 32'(clk0), err);
    apb_write(12'h004, 32'(rst0), err);
    t = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst0[i]) begin
        set_t[i] = t + 2; rel_t[i] = t + gap + 4; t += 2 * gap + 6;
      end else begin
        set_t[i] = -1; rel_t[i] = -1; t += 2;
      end
    end
    apb_write(12'h00C, 32'h1, err);
    check({tag, "_start_err"}, 32'(err), 32'h0);
    bad_c = 0; bad_r = 0; bad_b = 0; bad_i = 0;
    a_c = 0; x_c = 0; a_r = 0; x_r = 0; a_b = 0; x_b = 0; a_i = 0; x_i = 0;
    for (int k = 0; k <= t + 2; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      e_clk = clk0;
      e_rn  = ~rst0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (set_t[i] >= 0 && k >= set_t[i]) e_clk[i] = 1'b1;
        if (rel_t[i] >= 0 && k >= rel_t[i]) e_rn[i]  = 1'b1;
      end
      if (!bad_c) begin a_c = 32'(ch_clk_en); x_c = 32'(e_clk); bad_c = (a_c != x_c); end
      if (!bad_r) begin a_r = 32'(ch_rst_n);  x_r = 32'(e_rn);  bad_r = (a_r != x_r); end
      if (!bad_b) begin a_b = 32'(seq_busy); x_b = 32'(k < t); bad_b = (a_b != x_b); end
      if (!bad_i) begin a_i = 32'(seq_done_irq); x_i = 32'(k == t); bad_i = (a_i != x_i); end
    end
    check({tag, "_clk_en_trace"}, a_c, x_c);
    check({tag, "_rst_n_trace"}, a_r, x_r);
    check({tag, "_busy_trace"}, a_b, x_b);
    check({tag, "_irq_trace"}, a_i, x_i);
    apb_read(12'h00C, rd, err);
    check({tag, "_seq_ctrl"}, rd, 32'h2);
    apb_read(12'h000, rd, err);
    check({tag, "_clk_en_final"}, rd, 32'(clk0 | rst0));
    apb_read(12'h004, rd, err);
    check({tag, "_rst_final"}, rd, 32'h0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic err;
    logic [31:0] rd;
    int irq0, busy0;
    apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = '0; apb.PWDATA = '0;

    #12;
    check("rst_ch_clk_en", 32'(ch_clk_en), 32'h0);
    check("rst_ch_rst_n", 32'(ch_rst_n), 32'h0);
    check("rst_busy", 32'(seq_busy), 32'h0);
    check("rst_irq", 32'(seq_done_irq), 32'h0);
    check("rst_pslverr", 32'(apb.PSLVERR), 32'h0);
    check("rst_prdata", apb.PRDATA, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    add(0, 12'h000, 0, 32'h0,          0, "rd_clk_en");
    add(0, 12'h004, 0, 32'hFF,         0, "rd_rst_assert");
    add(0, 12'h008, 0, 32'h0,          0, "rd_gap");
    add(0, 12'h00C, 0, 32'h0,          0, "rd_seq_ctrl");
    add(0, 12'h010, 0, 32'hC2C0_0802,  0, "rd_id");
    add(0, 12'h018, 0, 32'h0,          1, "rd_unmapped");
    add(0, 12'h002, 0, 32'h0,          1, "rd_misaligned");
    add(1, 12'h010, 32'h123, 0,        1, "wr_id");
    add(0, 12'h010, 0, 32'hC2C0_0802,  0, "rd_id_again");
    add(1, 12'h008, 32'h1AB, 0,        0, "wr_gap");
    add(0, 12'h008, 0, 32'hAB,         0, "rd_gap_masked");
    add(1, 12'h000, 32'hFFFF_FF0F, 0,  0, "wr_clk_en");
    add(0, 12'h000, 0, 32'h0F,         0, "rd_clk_en_masked");
    add(1, 12'h004, 32'h130, 0,        0, "wr_rst");
    add(0, 12'h004, 0, 32'h30,         0, "rd_rst_masked");
    add(1, 12'h00C, 32'h2, 0,          0, "wr_clr_done");
    add(0, 12'h00C, 0, 32'h0,          0, "rd_seq_ctrl_idle");
    add(1, 12'h020, 32'h5, 0,          1, "wr_unmapped");
    add(1, 12'h006, 32'hFF, 0,         1, "wr_misaligned");
    add(0, 12'h004, 0, 32'h30,         0, "rd_rst_unchanged");
`ifdef CRCU_SOFT_RST_EN
    add(0, 12'h014, 0, 32'h0,          0, "rd_swrst");
    add(1, 12'h014, 32'h1234, 0,       1, "wr_swrst_badkey");
`else
    add(0, 12'h014, 0, 32'h0,          1, "rd_swrst_unmapped");
    add(1, 12'h014, 32'h5AFE, 0,       1, "wr_swrst_unmapped");
`endif
    add(0, 12'h000, 0, 32'h0F,         0, "rd_clk_en_kept");

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        apb_write(vecs[i].addr, vecs[i].wdata, err);
      end else begin
        apb_read(vecs[i].addr, rd, err);
        check({vecs[i].name, "_data"}, rd, vecs[i].exp_rdata);
      end
      check({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
    end
    check("tbl_ch_clk_en", 32'(ch_clk_en), 32'h0F);
    check("tbl_ch_rst_n", 32'(ch_rst_n), 32'hCF);

    run_seq("gap3_all", 3, 8'h00, 8'hFF);
    run_seq("gap0_ch02", 0, 8'hFA, 8'h05);
    run_seq("all_skip", 2, 8'h5A, 8'h00);

    // Busy-time protections: blocked writes, ignored second START
    apb_write(12'h008, 32'd20, err);
    apb_write(12'h000, 32'h0, err);
    apb_write(12'h004, 32'h01, err);
    irq0 = mon_irq; busy0 = mon_busy;
    apb_write(12'h00C, 32'h1, err);
    apb_write(12'h000, 32'h0F, err);
    check("busy_wr_clk_en_err", 32'(err), 32'h1);
    apb_write(12'h004, 32'hF0, err);
    check("busy_wr_rst_err", 32'(err), 32'h1);
    apb_write(12'h00C, 32'h1, err);
    check("busy_restart_err", 32'(err), 32'h0);
    apb_write(12'h002, 32'h1, err);
    check("busy_misaligned_err", 32'(err), 32'h1);
    for (int k = 0; k < 300 && seq_busy; k++) @(posedge clk);
    check("busy_timeout", 32'(seq_busy), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("busy_cycles", 32'(mon_busy - busy0), 32'd60);
    check("busy_irq_count", 32'(mon_irq - irq0), 32'd1);
    apb_read(12'h000, rd, err);
    check("busy_clk_en_final", rd, 32'h01);
    apb_read(12'h004, rd, err);
    check("busy_rst_final", rd, 32'h0);

    // Reset dropped while channel 3 is in its post-release hold
    apb_write(12'h008, 32'd3, err);
    apb_write(12'h000, 32'h0, err);
    apb_write(12'h004, 32'hFF, err);
    apb_write(12'h00C, 32'h1, err);
    repeat (44) @(posedge clk);
    #1;
    check("mid_ch_clk_en", 32'(ch_clk_en), 32'h0F);
    check("mid_ch_rst_n", 32'(ch_rst_n), 32'h0F);
    check("mid_busy", 32'(seq_busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ch_clk_en", 32'(ch_clk_en), 32'h0);
    check("arst_ch_rst_n", 32'(ch_rst_n), 32'h0);
    check("arst_busy", 32'(seq_busy), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    apb_read(12'h008, rd, err);
    check("arst_gap", rd, 32'h0);
    apb_read(12'h00C, rd, err);
    check("arst_seq_ctrl", rd, 32'h0);
    run_seq("rerun", 0, 8'h00, 8'hFF);

`ifdef CRCU_SOFT_RST_EN
    apb_write(12'h008, 32'd3, err);
    apb_write(12'h000, 32'h0, err);
    apb_write(12'h004, 32'hFF, err);
    irq0 = mon_irq;
    apb_write(12'h00C, 32'h1, err);
    repeat (20) @(posedge clk);
    apb_write(12'h014, 32'h0000_5AFE, err);
    check("swrst_err", 32'(err), 32'h0);
    check("swrst_ch_clk_en", 32'(ch_clk_en), 32'h0);
    check("swrst_ch_rst_n", 32'(ch_rst_n), 32'h0);
    check("swrst_busy", 32'(seq_busy), 32'h0);
    repeat (120) @(posedge clk);
    #1;
    check("swrst_no_irq", 32'(mon_irq - irq0), 32'h0);
    apb_read(12'h00C, rd, err);
    check("swrst_seq_ctrl", rd, 32'h0);
    apb_write(12'h000, 32'h3C, err);
    apb_write(12'h014, 32'h1234, err);
    check("swrst_badkey_err", 32'(err), 32'h1);
    check("swrst_badkey_clk_en", 32'(ch_clk_en), 32'h3C);
`endif

    for (int it = 0; it < 6; it++) begin
      run_seq($sformatf("rand%0d", it), int'($urandom_range(0, 5)),
              NUM_CH'($urandom), NUM_CH'($urandom));
    end
    run_seq("gap_max", 255, 8'h00, 8'h81);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
